// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and constants for the pixel write-back path.
//   state_t  - pixel_writer controller states
//   pixel_t  - queued pixel {index, rgba}
//   FB_*     - frame buffer geometry
//   *_LSB    - bit position of each colour field inside an rgba word
package gpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_BLEND,
        S_WR_REQ,
        S_SWAP
    } state_t;

    localparam int unsigned FB_WIDTH  = 640;
    localparam int unsigned FB_HEIGHT = 480;
    localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned PIX_W     = 19;

    localparam int unsigned R_LSB = 24;
    localparam int unsigned G_LSB = 16;
    localparam int unsigned B_LSB = 8;
    localparam int unsigned A_LSB = 0;

    typedef struct packed {
        logic [PIX_W-1:0] num;
        logic [31:0]      rgba;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO with a registered head word.
//   i_clk, i_reset    - clock, synchronous active-high reset
//   i_push/i_push_data - enqueue (ignored when full)
//   i_pop             - dequeue (ignored when empty)
//   o_head            - oldest entry, valid while !o_empty
//   o_full, o_empty   - occupancy flags
// DEPTH must be a power of two, at least 2.
module pixel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 51
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_rd_next;

    assign o_full    = (r_count == COUNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_head;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_rd_next = w_do_pop ? r_rd + AW'(1) : r_rd;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            r_rd <= w_rd_next;
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
            // The incoming word becomes the head when it lands in the slot the
            // read pointer moves to (queue empty, or emptied by this pop).
            if (w_do_push && (r_wr == w_rd_next)) begin
                r_head <= i_push_data;
            end else begin
                r_head <= r_mem[w_rd_next];
            end
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: queues rasteriser pixels and writes them into the back frame
// buffer over a req/ack bus, alpha-blending partially transparent pixels
// against memory. frame_ready drains the queue, swaps buffers and pulses
// frame_done.
//   clk, reset                 - clock, synchronous active-high reset
//   get_pixel, pixel_number,
//   rgba, pixel_ready          - pixel input strobe and back-pressure
//   frame_ready                - end-of-frame strobe
//   mem_req/we/addr/wdata,
//   mem_rdata, mem_ack         - memory bus
//   frame_done, display_base   - buffer swap pulse and current front buffer
//   overflow                   - sticky: a strobe was dropped while not ready
module pixel_writer
    import gpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_A     = 32'h0000_0000,
    parameter logic [31:0] BASE_B     = 32'h0012_C000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        get_pixel,
    input  logic [18:0] pixel_number,
    input  logic [31:0] rgba,
    output logic        pixel_ready,
    input  logic        frame_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        frame_done,
    output logic [31:0] display_base,
    output logic        overflow
);

    state_t      r_state;
    logic        r_flush;
    logic [31:0] r_rgba;
    logic [31:0] r_dst;
    logic [31:0] r_back_base;

    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_do_swap;
    pixel_t      w_push_data;
    pixel_t      w_head;
    logic [7:0]  w_head_alpha;
    logic [31:0] w_offset;
    logic [31:0] w_blended;

    function automatic logic [7:0] blend_ch(input logic [7:0] s,
                                            input logic [7:0] d,
                                            input logic [7:0] a);
        logic [15:0] acc;
        acc = 16'(s) * 16'(a) + 16'(d) * 16'(8'hFF - a);
        return acc[15:8];
    endfunction

    assign pixel_ready  = !w_full && !r_flush;
    assign w_push       = get_pixel && pixel_ready && ({13'd0, pixel_number} < FB_PIXELS);
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_push_data  = {pixel_number, rgba};
    assign w_head_alpha = w_head.rgba[A_LSB +: 8];
    assign w_offset     = {11'd0, w_head.num, 2'b00};

    // Swap once the last queued pixel has been written: either straight from
    // the final write ack, or from IDLE when nothing was outstanding.
    assign w_do_swap = r_flush && w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_WR_REQ) && mem_ack));

    assign w_blended = {blend_ch(r_rgba[R_LSB +: 8], r_dst[R_LSB +: 8], r_rgba[A_LSB +: 8]),
                        blend_ch(r_rgba[G_LSB +: 8], r_dst[G_LSB +: 8], r_rgba[A_LSB +: 8]),
                        blend_ch(r_rgba[B_LSB +: 8], r_dst[B_LSB +: 8], r_rgba[A_LSB +: 8]),
                        8'hFF};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pixel_t))
    ) u_fifo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_flush      <= 1'b0;
            r_rgba       <= '0;
            r_dst        <= '0;
            r_back_base  <= BASE_A;
            display_base <= BASE_B;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_ready) begin
                r_flush <= 1'b1;
            end
            if (get_pixel && !pixel_ready) begin
                overflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_rgba   <= w_head.rgba;
                        mem_addr <= r_back_base + w_offset;
                        if (w_head_alpha == 8'hFF) begin
                            mem_wdata <= {w_head.rgba[31:8], 8'hFF};
                            mem_we    <= 1'b1;
                            mem_req   <= 1'b1;
                            r_state   <= S_WR_REQ;
                        end else if (w_head_alpha != 8'h00) begin
                            mem_we  <= 1'b0;
                            mem_req <= 1'b1;
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (mem_ack) begin
                        r_dst   <= mem_rdata;
                        mem_req <= 1'b0;
                        r_state <= S_BLEND;
                    end
                end
                S_BLEND: begin
                    mem_wdata <= w_blended;
                    mem_we    <= 1'b1;
                    mem_req   <= 1'b1;
                    r_state   <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SWAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_do_swap) begin
                display_base <= r_back_base;
                r_back_base  <= (r_back_base == BASE_A) ? BASE_B : BASE_A;
                frame_done   <= 1'b1;
                r_flush      <= 1'b0;
                r_state      <= S_SWAP;
            end
        end
    end

endmodule
